// File: rtl/cnn_conv1x3_stream.sv
// Streaming 1x3 horizontal convolution: bias, ReLU and saturation on each
// complete in-row window, with the result registered one cycle after the window completes.
module cnn_conv1x3_stream #(
    parameter int DATA_W = 8,
    parameter int FRAC   = 4,
    parameter int IMG_W  = 4,
    parameter int W0     = 4,
    parameter int W1     = 8,
    parameter int W2     = 4,
    parameter int BIAS   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] pixel_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    localparam int ACC_W = 2*DATA_W + 2;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic signed [DATA_W-1:0] L_W0   = DATA_W'(W0);
    localparam logic signed [DATA_W-1:0] L_W1   = DATA_W'(W1);
    localparam logic signed [DATA_W-1:0] L_W2   = DATA_W'(W2);
    localparam logic signed [DATA_W-1:0] L_BIAS = DATA_W'(BIAS);
    localparam logic signed [ACC_W-1:0]  L_MAX  = ACC_W'((1 << (DATA_W-1)) - 1);
    localparam logic [COL_W-1:0]         L_LAST = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0]         L_TWO  = COL_W'(2);

    logic [COL_W-1:0]         r_col;
    logic signed [DATA_W-1:0] r_p1;
    logic signed [DATA_W-1:0] r_p2;
    logic                     r_out_valid;
    logic [DATA_W-1:0]        r_out_data;

    logic signed [DATA_W-1:0] w_pix;
    logic signed [ACC_W-1:0]  w_prod0;
    logic signed [ACC_W-1:0]  w_prod1;
    logic signed [ACC_W-1:0]  w_prod2;
    logic signed [ACC_W-1:0]  w_bias;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W-1:0]  w_scaled;
    logic [DATA_W-1:0]        w_result;
    logic                     w_window;

    assign w_pix    = pixel_in;
    assign w_window = in_valid && (r_col >= L_TWO);

    // Operands are sign-extended to the accumulator width before multiplying.
    always_comb begin
        w_prod0  = ACC_W'(r_p2)  * ACC_W'(L_W0);
        w_prod1  = ACC_W'(r_p1)  * ACC_W'(L_W1);
        w_prod2  = ACC_W'(w_pix) * ACC_W'(L_W2);
        w_bias   = ACC_W'(L_BIAS) <<< FRAC;
        w_acc    = w_prod0 + w_prod1 + w_prod2 + w_bias;
        w_scaled = w_acc >>> FRAC;
    end

    always_comb begin
        w_result = '0;
        if (w_scaled < 0) begin
            w_result = '0;
        end else if (w_scaled > L_MAX) begin
            w_result = L_MAX[DATA_W-1:0];
        end else begin
            w_result = w_scaled[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_p1  <= '0;
            r_p2  <= '0;
        end else if (in_valid) begin
            r_p1  <= w_pix;
            r_p2  <= r_p1;
            r_col <= (r_col == L_LAST) ? '0 : r_col + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_window;
            if (w_window) begin
                r_out_data <= w_result;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_cnn_conv1x3_stream.sv
// Bench for cnn_conv1x3_stream: three parameterisations driven by one stream,
// compared each cycle against a row-buffer arithmetic model.
module tb_cnn_conv1x3_stream;

    localparam int IMG_W = 4;
    localparam int NI    = 3;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] pixel_in;
    logic       ov [NI];
    logic [7:0] od [NI];

    int         cw0   [NI] = '{4, 16, 4};
    int         cw1   [NI] = '{8, 16, 8};
    int         cw2   [NI] = '{4, 16, 4};
    int         cbias [NI] = '{0, 0, -1};

    int         row [IMG_W];
    int         col;
    logic       exp_v;
    logic [7:0] exp_d [NI];
    int         errors;
    int         checks;

    cnn_conv1x3_stream u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pixel_in(pixel_in),
        .out_valid(ov[0]), .out_data(od[0])
    );

    cnn_conv1x3_stream #(.W0(16), .W1(16), .W2(16)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pixel_in(pixel_in),
        .out_valid(ov[1]), .out_data(od[1])
    );

    cnn_conv1x3_stream #(.BIAS(-1)) u_bias (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pixel_in(pixel_in),
        .out_valid(ov[2]), .out_data(od[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int conv_ref(input int k, input int a, input int b, input int c);
        int acc;
        int q;
        acc = cw0[k]*a + cw1[k]*b + cw2[k]*c + cbias[k]*16;
        q   = acc >>> 4;
        if (q < 0)   q = 0;
        if (q > 127) q = 127;
        return q;
    endfunction

    task automatic model_reset();
        col   = 0;
        exp_v = 1'b0;
        for (int unsigned k = 0; k < NI; k++) exp_d[k] = '0;
        for (int unsigned j = 0; j < IMG_W; j++) row[j] = 0;
    endtask

    task automatic check_all(input string tag);
        for (int unsigned k = 0; k < NI; k++) begin
            checks++;
            assert (ov[k] === exp_v) else begin
                errors++;
                $error("FAIL %s valid inst%0d: got %b want %b", tag, k, ov[k], exp_v);
            end
            checks++;
            assert (od[k] === exp_d[k]) else begin
                errors++;
                $error("FAIL %s data inst%0d: got %0d want %0d", tag, k, od[k], exp_d[k]);
            end
        end
    endtask

    task automatic step(input logic v, input int pix, input string tag);
        in_valid = v;
        pixel_in = 8'(pix);
        @(posedge clk);
        #1;
        exp_v = 1'b0;
        if (v) begin
            if (col >= 2) begin
                exp_v = 1'b1;
                for (int unsigned k = 0; k < NI; k++)
                    exp_d[k] = 8'(conv_ref(k, row[col-2], row[col-1], pix));
            end
            row[col] = pix;
            col = (col == IMG_W-1) ? 0 : col + 1;
        end
        check_all(tag);
    endtask

    task automatic feed_row(input int a, input int b, input int c, input int d, input string tag);
        step(1'b1, a, tag);
        step(1'b1, b, tag);
        step(1'b1, c, tag);
        step(1'b1, d, tag);
    endtask

    int basic [8] = '{10, 20, 30, 40, 50, 60, 70, 80};

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        pixel_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        for (int i = 0; i < 8; i++) step(1'b1, basic[i], "basic");

        for (int i = 0; i < 8; i++) begin
            int gap;
            gap = int'($urandom_range(1, 3));
            for (int g = 0; g < gap; g++) step(1'b0, int'($urandom_range(0, 255)) - 128, "gap_idle");
            step(1'b1, basic[i], "gapped");
        end

        feed_row(-80, -80, -80, -80, "relu");
        feed_row(127, 127, 127, 127, "saturate");
        feed_row(1, 1, 1, 1, "bias_ones");
        feed_row(-1, -1, -1, -1, "floor_neg");

        step(1'b1, 10, "async_pre");
        step(1'b1, 20, "async_pre");
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_clear");
        @(posedge clk);
        #1;
        check_all("async_hold");
        rst = 1'b1;
        feed_row(30, 40, 50, 60, "after_reset");

        for (int i = 0; i < 120; i++) begin
            logic v;
            v = ($urandom_range(0, 3) != 0);
            step(v, int'($urandom_range(0, 255)) - 128, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
